// File: rtl/ddr3_wb_width_bridge.sv
// Narrow (32-bit) to wide DDR3 Wishbone bridge with optional
// one-line read buffer, abort and error handling.
module ddr3_wb_width_bridge #(
  parameter int NUM_DQ_BITS = 8,
  parameter int LANES = 2,
  parameter int SERDES_RATIO = 4,
  parameter int ROW_BITS = 15,
  parameter int COL_BITS = 10,
  parameter int BA_BITS = 3,
  parameter int OPT_READ_BUFFER = 1,
  localparam int WIDE_DW = NUM_DQ_BITS * LANES * SERDES_RATIO * 2,
  localparam int WIDE_AW = ROW_BITS + COL_BITS + BA_BITS
                         - $clog2(SERDES_RATIO * 2),
  localparam int WPL = WIDE_DW / 32,
  localparam int IW = $clog2(WPL),
  localparam int NARROW_AW = WIDE_AW + IW,
  localparam int SW = WIDE_DW / 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [NARROW_AW-1:0] wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  output logic                 wb_stall_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [31:0]          wb_dat_o,
  output logic                 ddr_cyc_o,
  output logic                 ddr_stb_o,
  output logic                 ddr_we_o,
  output logic [WIDE_AW-1:0]   ddr_adr_o,
  output logic [WIDE_DW-1:0]   ddr_dat_o,
  output logic [SW-1:0]        ddr_sel_o,
  input  logic                 ddr_stall_i,
  input  logic                 ddr_ack_i,
  input  logic                 ddr_err_i,
  input  logic [WIDE_DW-1:0]   ddr_dat_i,
  input  logic                 inv_i
);

  localparam logic BUF_EN = (OPT_READ_BUFFER != 0);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t state, state_nx;

  logic               req_we;
  logic [WIDE_AW-1:0] req_line;
  logic [IW-1:0]      req_idx;
  logic [31:0]        req_dat;
  logic [3:0]         req_sel;
  logic               aborted;
  logic               failed;
  logic [WIDE_DW-1:0] line_q;
  logic [WIDE_AW-1:0] tag;
  logic               valid;

  logic               req;
  logic [WIDE_AW-1:0] adr_line;
  logic               hit;
  logic               buf_hit;
  logic [31:0]        word;

  assign req      = wb_cyc_i & wb_stb_i;
  assign adr_line = wb_adr_i[NARROW_AW-1:IW];
  assign hit      = BUF_EN & valid & ~wb_we_i
                  & (tag == adr_line);
  assign buf_hit  = valid & (tag == req_line);
  assign word     = line_q[32*int'(req_idx) +: 32];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req) state_nx = hit ? RESP : ISSUE;
      ISSUE: begin
        if (!wb_cyc_i)        state_nx = IDLE;
        else if (!ddr_stall_i) state_nx = WAIT;
      end
      WAIT:  if (ddr_ack_i || ddr_err_i) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wb_stall_o = (state != IDLE);
    wb_ack_o   = 1'b0;
    wb_err_o   = 1'b0;
    wb_dat_o   = '0;
    ddr_cyc_o  = 1'b0;
    ddr_stb_o  = 1'b0;
    ddr_we_o   = 1'b0;
    ddr_adr_o  = '0;
    ddr_dat_o  = '0;
    ddr_sel_o  = '0;
    unique case (state)
      ISSUE: begin
        ddr_cyc_o = wb_cyc_i;
        ddr_stb_o = wb_cyc_i;
        ddr_we_o  = wb_cyc_i & req_we;
        ddr_adr_o = req_line;
        if (req_we) begin
          ddr_dat_o = {WPL{req_dat}};
          ddr_sel_o = SW'(req_sel) << {req_idx, 2'b00};
        end else begin
          ddr_sel_o = '1;
        end
      end
      WAIT: ddr_cyc_o = 1'b1;
      RESP: begin
        wb_ack_o = ~aborted & ~failed;
        wb_err_o = ~aborted & failed;
        if (!aborted && !failed && !req_we) wb_dat_o = word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_we   <= 1'b0;
      req_line <= '0;
      req_idx  <= '0;
      req_dat  <= '0;
      req_sel  <= '0;
      aborted  <= 1'b0;
      failed   <= 1'b0;
      line_q   <= '0;
      tag      <= '0;
      valid    <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        req_we   <= wb_we_i;
        req_line <= adr_line;
        req_idx  <= wb_adr_i[IW-1:0];
        req_dat  <= wb_dat_i;
        req_sel  <= wb_sel_i;
        aborted  <= 1'b0;
        failed   <= 1'b0;
      end
      if (state == WAIT && !wb_cyc_i) aborted <= 1'b1;
      if (state == WAIT && ddr_ack_i) begin
        if (!req_we) begin
          line_q <= ddr_dat_i;
          tag    <= req_line;
          valid  <= BUF_EN;
        end else if (buf_hit) begin
          for (int b = 0; b < 4; b++)
            if (req_sel[b])
              line_q[32*int'(req_idx) + 8*b +: 8] <= req_dat[8*b +: 8];
        end
      end else if (state == WAIT && ddr_err_i) begin
        failed <= 1'b1;
        valid  <= 1'b0;
      end
      // invalidate last so a coincident fill still ends invalid
      if (inv_i || !BUF_EN) valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr3_wb_width_bridge.sv
// Directed bench for ddr3_wb_width_bridge: reset, misses, hits,
// write merge, stalls, aborts, errors and invalidation.
module tb_ddr3_wb_width_bridge;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [26:0]  wb_adr_i = '0;
  logic [31:0]  wb_dat_i = '0;
  logic [3:0]   wb_sel_i = '0;
  logic         wb_stall_o, wb_ack_o, wb_err_o;
  logic [31:0]  wb_dat_o;
  logic         ddr_cyc_o, ddr_stb_o, ddr_we_o;
  logic [24:0]  ddr_adr_o;
  logic [127:0] ddr_dat_o;
  logic [15:0]  ddr_sel_o;
  logic         ddr_stall_i = 1'b0, ddr_ack_i = 1'b0, ddr_err_i = 1'b0;
  logic [127:0] ddr_dat_i = '0;
  logic         inv_i = 1'b0;

  ddr3_wb_width_bridge dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_stall_o(wb_stall_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_dat_o(wb_dat_o),
    .ddr_cyc_o(ddr_cyc_o), .ddr_stb_o(ddr_stb_o), .ddr_we_o(ddr_we_o),
    .ddr_adr_o(ddr_adr_o), .ddr_dat_o(ddr_dat_o), .ddr_sel_o(ddr_sel_o),
    .ddr_stall_i(ddr_stall_i), .ddr_ack_i(ddr_ack_i),
    .ddr_err_i(ddr_err_i), .ddr_dat_i(ddr_dat_i), .inv_i(inv_i)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [127:0] LINE4 =
    128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;

  logic [206:0] all_out;
  assign all_out = {wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o,
                    ddr_cyc_o, ddr_stb_o, ddr_we_o, ddr_adr_o,
                    ddr_dat_o, ddr_sel_o};

  int pass_n = 0;
  int total_n = 0;

  int           o_stb, o_ack, o_err, o_ack_c, o_waitcyc;
  logic         o_stable, o_stall0, o_post_stall, o_extra, o_we;
  logic [24:0]  o_adr;
  logic [127:0] o_ddat;
  logic [15:0]  o_sel;
  logic [31:0]  o_rdata;

  function automatic logic [127:0] line_data(input int l);
    logic [127:0] d;
    if (l == 4) return LINE4;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {16'(l), 16'(k)};
    return d;
  endfunction

  // Drives one request (caller is at a falling edge) and plays the
  // DDR controller; records what was observed in the o_* variables.
  task automatic do_req(input logic we, input logic [26:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int stall_n, input int ack_dly,
                        input logic use_err, input int abort_at,
                        input logic inv_at_ack, input int limit);
    int stall_left, ack_at;
    logic done;
    stall_left = stall_n; ack_at = -1; done = 1'b0;
    o_stb = 0; o_ack = 0; o_err = 0; o_ack_c = -1; o_waitcyc = 0;
    o_stable = 1'b1; o_rdata = '0; o_adr = '0; o_ddat = '0;
    o_sel = '0; o_we = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    #1 o_stall0 = wb_stall_o;
    for (int c = 1; c <= limit && !done; c++) begin
      @(negedge clk_i);
      wb_stb_i = 1'b0;
      if (c == abort_at) wb_cyc_i = 1'b0;
      ddr_ack_i = (c == ack_at) && !use_err;
      ddr_err_i = (c == ack_at) && use_err;
      inv_i     = (c == ack_at) && inv_at_ack;
      ddr_dat_i = (c == ack_at) ? line_data(int'(adr[26:2])) : '0;
      #1;
      if (ddr_stb_o) begin
        if (o_stb == 0) begin
          o_adr = ddr_adr_o; o_ddat = ddr_dat_o;
          o_sel = ddr_sel_o; o_we = ddr_we_o;
        end else if ({ddr_adr_o, ddr_dat_o, ddr_sel_o, ddr_we_o}
                     !== {o_adr, o_ddat, o_sel, o_we}) begin
          o_stable = 1'b0;
        end
        o_stb++;
        ddr_stall_i = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        else ack_at = c + ack_dly;
      end else begin
        ddr_stall_i = 1'b0;
        if (ddr_cyc_o) o_waitcyc++;
      end
      if (wb_ack_o) begin
        o_ack++; o_ack_c = c; o_rdata = wb_dat_o; done = 1'b1;
      end
      if (wb_err_o) begin
        o_err++; o_ack_c = c; done = 1'b1;
      end
    end
    @(negedge clk_i);
    ddr_ack_i = 1'b0; ddr_err_i = 1'b0; inv_i = 1'b0; ddr_stall_i = 1'b0;
    #1 o_extra = wb_ack_o | wb_err_o;
    o_post_stall = wb_stall_o;
  endtask

  task automatic test_reset();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 27'h10;
    repeat (2) @(negedge clk_i);
    #1;
    total_n++; if (all_out !== '0) $display("FAIL reset_outputs got %h want 0", all_out); else pass_n++;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_read_miss();
    do_req(1'b0, 27'h10, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stall0 !== 1'b0) $display("FAIL miss_stall0 got %b want 0", o_stall0); else pass_n++;
    total_n++; if (o_stb !== 1) $display("FAIL miss_stb_cycles got %0d want 1", o_stb); else pass_n++;
    total_n++; if (o_adr !== 25'h4) $display("FAIL miss_adr got %h want 4", o_adr); else pass_n++;
    total_n++; if (o_sel !== 16'hFFFF) $display("FAIL miss_sel got %h want ffff", o_sel); else pass_n++;
    total_n++; if (o_we !== 1'b0) $display("FAIL miss_we got %b want 0", o_we); else pass_n++;
    total_n++; if (o_waitcyc !== 1) $display("FAIL miss_wait_cyc got %0d want 1", o_waitcyc); else pass_n++;
    total_n++; if (o_ack !== 1 || o_err !== 0) $display("FAIL miss_ack got %0d/%0d want 1/0", o_ack, o_err); else pass_n++;
    total_n++; if (o_ack_c !== 3) $display("FAIL miss_latency got %0d want 3", o_ack_c); else pass_n++;
    total_n++; if (o_rdata !== 32'hAAAAAAAA) $display("FAIL miss_rdata got %h want aaaaaaaa", o_rdata); else pass_n++;
  endtask

  task automatic test_read_hits();
    logic [31:0] exp_w[3];
    exp_w[0] = 32'hBBBBBBBB; exp_w[1] = 32'hCCCCCCCC; exp_w[2] = 32'hDDDDDDDD;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 27'h11 + 27'(i), '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
      total_n++; if (o_stall0 !== 1'b0) $display("FAIL hit%0d_stall0 got %b want 0", i, o_stall0); else pass_n++;
      total_n++; if (o_stb !== 0) $display("FAIL hit%0d_stb got %0d want 0", i, o_stb); else pass_n++;
      total_n++; if (o_ack_c !== 1 || o_ack !== 1) $display("FAIL hit%0d_latency got %0d acks %0d want 1 1", i, o_ack_c, o_ack); else pass_n++;
      total_n++; if (o_rdata !== exp_w[i]) $display("FAIL hit%0d_rdata got %h want %h", i, o_rdata, exp_w[i]); else pass_n++;
      total_n++; if (o_extra !== 1'b0 || o_post_stall !== 1'b0) $display("FAIL hit%0d_after got ack %b stall %b want 0 0", i, o_extra, o_post_stall); else pass_n++;
    end
  endtask

  task automatic test_write_merge();
    do_req(1'b1, 27'h12, 32'hDEADBEEF, 4'b0011, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_sel !== 16'h0300) $display("FAIL wr_sel got %h want 0300", o_sel); else pass_n++;
    total_n++; if (o_ddat !== {4{32'hDEADBEEF}}) $display("FAIL wr_dat got %h want 4xdeadbeef", o_ddat); else pass_n++;
    total_n++; if (o_we !== 1'b1 || o_adr !== 25'h4) $display("FAIL wr_we_adr got %b %h want 1 4", o_we, o_adr); else pass_n++;
    total_n++; if (o_ack !== 1 || o_ack_c !== 3 || o_rdata !== 0) $display("FAIL wr_ack got %0d at %0d dat %h want 1 at 3 dat 0", o_ack, o_ack_c, o_rdata); else pass_n++;
    do_req(1'b0, 27'h12, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 0 || o_ack_c !== 1) $display("FAIL wr_rehit got stb %0d at %0d want 0 at 1", o_stb, o_ack_c); else pass_n++;
    total_n++; if (o_rdata !== 32'hCCCCBEEF) $display("FAIL wr_merged got %h want ccccbeef", o_rdata); else pass_n++;
    do_req(1'b1, 27'h40, 32'h12345678, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_sel !== 16'h000F || o_adr !== 25'h10) $display("FAIL wrmiss_sel_adr got %h %h want 000f 10", o_sel, o_adr); else pass_n++;
    do_req(1'b0, 27'h13, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 0 || o_rdata !== 32'hDDDDDDDD) $display("FAIL wrmiss_untouched got stb %0d dat %h want 0 dddddddd", o_stb, o_rdata); else pass_n++;
  endtask

  task automatic test_stall();
    do_req(1'b0, 27'h17, '0, 4'hF, 3, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 4) $display("FAIL stall_stb_cycles got %0d want 4", o_stb); else pass_n++;
    total_n++; if (o_stable !== 1'b1) $display("FAIL stall_stable got %b want 1", o_stable); else pass_n++;
    total_n++; if (o_ack !== 1 || o_ack_c !== 6) $display("FAIL stall_ack got %0d at %0d want 1 at 6", o_ack, o_ack_c); else pass_n++;
    total_n++; if (o_rdata !== 32'h00050003) $display("FAIL stall_rdata got %h want 00050003", o_rdata); else pass_n++;
    do_req(1'b0, 27'h15, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 0 || o_rdata !== 32'h00050001) $display("FAIL stall_hit got stb %0d dat %h want 0 00050001", o_stb, o_rdata); else pass_n++;
  endtask

  task automatic test_abort();
    do_req(1'b0, 27'h20, '0, 4'hF, 0, 3, 1'b0, 2, 1'b0, 10);
    total_n++; if (o_ack !== 0 || o_err !== 0) $display("FAIL abort_wait_resp got %0d/%0d want 0/0", o_ack, o_err); else pass_n++;
    total_n++; if (o_waitcyc !== 3) $display("FAIL abort_wait_cyc got %0d want 3", o_waitcyc); else pass_n++;
    do_req(1'b0, 27'h21, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 0 || o_rdata !== 32'h00080001) $display("FAIL abort_fill got stb %0d dat %h want 0 00080001", o_stb, o_rdata); else pass_n++;
    do_req(1'b0, 27'h30, '0, 4'hF, 5, 1, 1'b0, 2, 1'b0, 6);
    total_n++; if (o_stb !== 1 || o_ack !== 0) $display("FAIL abort_issue got stb %0d ack %0d want 1 0", o_stb, o_ack); else pass_n++;
    total_n++; if (o_post_stall !== 1'b0 || o_waitcyc !== 0) $display("FAIL abort_issue_idle got stall %b wait %0d want 0 0", o_post_stall, o_waitcyc); else pass_n++;
  endtask

  task automatic test_error();
    do_req(1'b0, 27'h30, '0, 4'hF, 0, 1, 1'b1, 0, 1'b0, 30);
    total_n++; if (o_err !== 1 || o_ack !== 0 || o_ack_c !== 3) $display("FAIL err_resp got err %0d ack %0d at %0d want 1 0 at 3", o_err, o_ack, o_ack_c); else pass_n++;
    total_n++; if (o_extra !== 1'b0) $display("FAIL err_single got %b want 0", o_extra); else pass_n++;
    do_req(1'b0, 27'h21, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 1 || o_rdata !== 32'h00080001) $display("FAIL err_invalid got stb %0d dat %h want 1 00080001", o_stb, o_rdata); else pass_n++;
  endtask

  task automatic test_inv();
    inv_i = 1'b1;
    @(negedge clk_i);
    inv_i = 1'b0;
    do_req(1'b0, 27'h22, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 1 || o_rdata !== 32'h00080002) $display("FAIL inv_miss got stb %0d dat %h want 1 00080002", o_stb, o_rdata); else pass_n++;
    do_req(1'b0, 27'h24, '0, 4'hF, 0, 1, 1'b0, 0, 1'b1, 30);
    total_n++; if (o_ack !== 1 || o_rdata !== 32'h00090000) $display("FAIL inv_fill_ack got %0d dat %h want 1 00090000", o_ack, o_rdata); else pass_n++;
    do_req(1'b0, 27'h25, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 1) $display("FAIL inv_same_cycle got stb %0d want 1", o_stb); else pass_n++;
    do_req(1'b0, 27'h26, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 0 || o_rdata !== 32'h00090002) $display("FAIL inv_refill_hit got stb %0d dat %h want 0 00090002", o_stb, o_rdata); else pass_n++;
  endtask

  task automatic test_reset_mid();
    do_req(1'b0, 27'h10, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 27'h50;
    @(negedge clk_i);
    wb_stb_i = 1'b0;
    #1;
    total_n++; if (ddr_stb_o !== 1'b1) $display("FAIL rstmid_issue got %b want 1", ddr_stb_o); else pass_n++;
    @(negedge clk_i);
    #1;
    total_n++; if (ddr_cyc_o !== 1'b1 || ddr_stb_o !== 1'b0) $display("FAIL rstmid_wait got %b%b want 10", ddr_cyc_o, ddr_stb_o); else pass_n++;
    #2 rstn_i = 1'b0;
    #1;
    total_n++; if (all_out !== '0) $display("FAIL rstmid_outputs got %h want 0", all_out); else pass_n++;
    @(negedge clk_i);
    wb_cyc_i = 1'b0;
    rstn_i = 1'b1;
    @(negedge clk_i);
    do_req(1'b0, 27'h10, '0, 4'hF, 0, 1, 1'b0, 0, 1'b0, 30);
    total_n++; if (o_stb !== 1 || o_rdata !== 32'hAAAAAAAA) $display("FAIL rstmid_miss got stb %0d dat %h want 1 aaaaaaaa", o_stb, o_rdata); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hits();
    test_write_merge();
    test_stall();
    test_abort();
    test_error();
    test_inv();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
